// File: rtl/temp_pkg.sv
// Shared types and widths for the temperature alarm filter.
package temp_pkg;

  localparam int TEMP_W = 8;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    PEND_HI = 2'd1,
    ALARM   = 2'd2,
    PEND_LO = 2'd3
  } alarm_state_t;

endpackage

// File: rtl/temp_window_avg.sv
// Sliding-window moving average over the last 2^WIN_LOG2 temperature samples.
module temp_window_avg
  import temp_pkg::*;
#(
  parameter int WIN_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [TEMP_W-1:0] temp,
  output logic [TEMP_W-1:0] avg,
  output logic              avg_valid
);

  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int SUM_W = TEMP_W + WIN_LOG2;
  localparam logic [WIN_LOG2:0] FILL_FULL = (WIN_LOG2 + 1)'(DEPTH);

  logic [TEMP_W-1:0]   r_buf [DEPTH];
  logic [SUM_W-1:0]    r_sum;
  logic [WIN_LOG2-1:0] r_wr_ptr;
  logic [WIN_LOG2:0]   r_fill;
  logic [TEMP_W-1:0]   r_avg;
  logic                r_avg_valid;

  logic [SUM_W-1:0]    w_sum_next;
  logic [WIN_LOG2:0]   w_fill_next;
  logic                w_full_next;

  // The evicted entry is subtracted unconditionally; the sum never underflows
  // because it always contains that entry.
  always_comb begin
    w_sum_next  = r_sum + SUM_W'(temp) - SUM_W'(r_buf[r_wr_ptr]);
    w_fill_next = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
    w_full_next = (w_fill_next == FILL_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the buffer is reset so the running sum stays equal to the sum of
      // its entries after a mid-stream reset.
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_sum       <= '0;
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      if (sample_valid) begin
        r_sum           <= w_sum_next;
        r_buf[r_wr_ptr] <= temp;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_fill          <= w_fill_next;
        if (w_full_next) begin
          r_avg       <= w_sum_next[SUM_W-1:WIN_LOG2];
          r_avg_valid <= 1'b1;
        end
      end
    end
  end

  assign avg       = r_avg;
  assign avg_valid = r_avg_valid;

endmodule

// File: rtl/temp_alarm_filter.sv
// Moving-average temperature filter with a debounced hysteresis alarm FSM.
module temp_alarm_filter
  import temp_pkg::*;
#(
  parameter int WIN_LOG2 = 2,
  parameter int DEBOUNCE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [TEMP_W-1:0] temp,
  input  logic [TEMP_W-1:0] hi_thresh,
  input  logic [TEMP_W-1:0] lo_thresh,
  output logic [TEMP_W-1:0] avg,
  output logic              avg_valid,
  output alarm_state_t      state,
  output logic              alarm,
  output logic              alarm_irq
);

  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE);

  logic [TEMP_W-1:0] w_avg;
  logic              w_avg_valid;

  alarm_state_t      r_state, w_state_next;
  logic [DEB_W-1:0]  r_deb, w_deb_next;
  logic              r_irq, w_irq_next;
  logic [DEB_W-1:0]  w_deb_inc;
  logic              w_deb_hit;

  temp_window_avg #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_window (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .temp         (temp),
    .avg          (w_avg),
    .avg_valid    (w_avg_valid)
  );

  // The counter is zero in NORMAL/ALARM, so DEBOUNCE=1 transitions directly.
  assign w_deb_inc = r_deb + 1'b1;
  assign w_deb_hit = (w_deb_inc == DEB_DONE);

  always_comb begin
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    w_state_next = r_state;
    w_deb_next   = r_deb;
    w_irq_next   = 1'b0;
    if (w_avg_valid) begin
      unique case (r_state)
        NORMAL, PEND_HI: begin
          if (w_avg >= hi_thresh) begin
            if (w_deb_hit) begin
              w_state_next = ALARM;
              w_deb_next   = '0;
              w_irq_next   = 1'b1;
            end else begin
              w_state_next = PEND_HI;
              w_deb_next   = w_deb_inc;
            end
          end else begin
            w_state_next = NORMAL;
            w_deb_next   = '0;
          end
        end
        ALARM, PEND_LO: begin
          if (w_avg <= lo_thresh) begin
            if (w_deb_hit) begin
              w_state_next = NORMAL;
              w_deb_next   = '0;
            end else begin
              w_state_next = PEND_LO;
              w_deb_next   = w_deb_inc;
            end
          end else begin
            w_state_next = ALARM;
            w_deb_next   = '0;
          end
        end
        default: begin
          w_state_next = NORMAL;
          w_deb_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= NORMAL;
      r_deb   <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_deb   <= w_deb_next;
      r_irq   <= w_irq_next;
    end
  end

  assign avg       = w_avg;
  assign avg_valid = w_avg_valid;
  assign state     = r_state;
  assign alarm     = (r_state == ALARM) || (r_state == PEND_LO);
  assign alarm_irq = r_irq;

endmodule
